// File: rtl/sky130_fd_io__amux_seq_pkg.sv
// rtl/sky130_fd_io__amux_seq_pkg.sv - shared types for the AMUX bus connection sequencer
package sky130_fd_io__amux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BREAK_DEAD,
        MAKE_SETTLE,
        DONE_ST
    } amux_state_t;

    localparam logic BUS_A = 1'b0;
    localparam logic BUS_B = 1'b1;

    // Wide enough for the largest supported channel count (16).
    localparam int CHAN_W_MAX = 4;

    typedef struct packed {
        logic [CHAN_W_MAX-1:0] chan;
        logic                  bus;
        logic                  conn;
    } amux_req_t;

endpackage

// File: rtl/sky130_fd_io__amux_seq_timer.sv
// rtl/sky130_fd_io__amux_seq_timer.sv - loadable down-counter that flags expiry at one
module sky130_fd_io__amux_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/sky130_fd_io__top_amux_seq_lvc.sv
// rtl/sky130_fd_io__top_amux_seq_lvc.sv - break-before-make sequencer for pad channels onto AMUXBUS_A/B
module sky130_fd_io__top_amux_seq_lvc
    import sky130_fd_io__amux_seq_pkg::*;
#(
    parameter int N_CHAN        = 4,
    parameter int CH_W          = $clog2(N_CHAN),
    parameter int DEAD_CYCLES   = 3,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [CH_W-1:0]   REQ_CHAN,
    input  logic              REQ_BUS,
    input  logic              REQ_CONN,
    output logic [N_CHAN-1:0] ENA_A,
    output logic [N_CHAN-1:0] ENA_B,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam logic [CHAN_W_MAX:0] N_CHAN_L = (CHAN_W_MAX + 1)'(N_CHAN);

    amux_state_t       state;
    amux_req_t         req_q;
    logic              dead_armed;
    logic              accept;
    logic              chan_bad;
    logic              is_noop;
    logic [N_CHAN-1:0] req_sel;
    logic [N_CHAN-1:0] cur_sel;
    logic [N_CHAN-1:0] tgt_vec;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_expire;
    logic [CNT_W-1:0]  tmr_val;

    assign accept   = REQ_VALID && REQ_READY;
    assign req_sel  = N_CHAN'(1) << REQ_CHAN;
    assign cur_sel  = N_CHAN'(1) << req_q.chan;
    assign chan_bad = {1'b0, CHAN_W_MAX'(REQ_CHAN)} >= N_CHAN_L;
    assign tgt_vec  = (REQ_BUS == BUS_B) ? ENA_B : ENA_A;
    assign is_noop  = REQ_CONN ? (tgt_vec == req_sel) : ((tgt_vec & req_sel) == '0);

    // The first dead cycle is the break itself; the timer only starts counting once armed.
    assign tmr_load = (accept && !chan_bad && !is_noop)
                   || (state == BREAK_DEAD && dead_armed && tmr_expire && req_q.conn);
    assign tmr_val  = (state == BREAK_DEAD) ? CNT_W'(SETTLE_CYCLES) : CNT_W'(DEAD_CYCLES);
    assign tmr_dec  = (state == MAKE_SETTLE) || (state == BREAK_DEAD && dead_armed);

    sky130_fd_io__amux_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (CLK),
        .rst      (RESET),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            req_q      <= '0;
            dead_armed <= 1'b0;
            ENA_A      <= '0;
            ENA_B      <= '0;
            REQ_READY  <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE, DONE_ST: begin
                    state     <= IDLE;
                    REQ_READY <= 1'b1;
                    BUSY      <= 1'b0;
                    if (accept) begin
                        if (chan_bad) begin
                            ERR <= 1'b1;
                        end else begin
                            req_q <= '{chan: CHAN_W_MAX'(REQ_CHAN), bus: REQ_BUS, conn: REQ_CONN};
                            if (is_noop) begin
                                state <= DONE_ST;
                                DONE  <= 1'b1;
                            end else begin
                                state      <= BREAK_DEAD;
                                REQ_READY  <= 1'b0;
                                BUSY       <= 1'b1;
                                dead_armed <= 1'b0;
                                // Connect empties the target bus and pulls the channel off the other one.
                                if (REQ_CONN) begin
                                    if (REQ_BUS == BUS_B) begin
                                        ENA_B <= '0;
                                        ENA_A <= ENA_A & ~req_sel;
                                    end else begin
                                        ENA_A <= '0;
                                        ENA_B <= ENA_B & ~req_sel;
                                    end
                                end else if (REQ_BUS == BUS_B) begin
                                    ENA_B <= ENA_B & ~req_sel;
                                end else begin
                                    ENA_A <= ENA_A & ~req_sel;
                                end
                            end
                        end
                    end
                end
                BREAK_DEAD: begin
                    dead_armed <= 1'b1;
                    if (dead_armed && tmr_expire) begin
                        if (req_q.conn) begin
                            state <= MAKE_SETTLE;
                            if (req_q.bus == BUS_B) begin
                                ENA_B <= cur_sel;
                            end else begin
                                ENA_A <= cur_sel;
                            end
                        end else begin
                            state     <= DONE_ST;
                            DONE      <= 1'b1;
                            REQ_READY <= 1'b1;
                            BUSY      <= 1'b0;
                        end
                    end
                end
                MAKE_SETTLE: begin
                    if (tmr_expire) begin
                        state     <= DONE_ST;
                        DONE      <= 1'b1;
                        REQ_READY <= 1'b1;
                        BUSY      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_one_on_a: assert property (@(posedge CLK) disable iff (RESET) $countones(ENA_A) <= 1);
    a_one_on_b: assert property (@(posedge CLK) disable iff (RESET) $countones(ENA_B) <= 1);
    a_no_both:  assert property (@(posedge CLK) disable iff (RESET) (ENA_A & ENA_B) == '0);
    a_bbm_a:    assert property (@(posedge CLK) disable iff (RESET)
                    !((|(ENA_A & ~$past(ENA_A))) && (|($past(ENA_A) & ~ENA_A))));
    a_bbm_b:    assert property (@(posedge CLK) disable iff (RESET)
                    !((|(ENA_B & ~$past(ENA_B))) && (|($past(ENA_B) & ~ENA_B))));

endmodule

// File: tb/tb_sky130_fd_io__top_amux_seq_lvc.sv
// tb/tb_sky130_fd_io__top_amux_seq_lvc.sv - directed bench for the AMUX bus sequencer
module tb_sky130_fd_io__top_amux_seq_lvc;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_chan;
    logic       req_bus;
    logic       req_conn;
    logic [2:0] ena_a;
    logic [2:0] ena_b;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sky130_fd_io__top_amux_seq_lvc #(
        .N_CHAN        (3),
        .DEAD_CYCLES   (3),
        .SETTLE_CYCLES (8),
        .CNT_W         (8)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_CHAN  (req_chan),
        .REQ_BUS   (req_bus),
        .REQ_CONN  (req_conn),
        .ENA_A     (ena_a),
        .ENA_B     (ena_b),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic [1:0] ch, input logic bus, input logic conn);
        req_chan  = ch;
        req_bus   = bus;
        req_conn  = conn;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_chan  = ~ch;
        req_bus   = ~bus;
        req_conn  = ~conn;
    endtask

    task automatic track(input string tag, input int n, input int rise_k, input int done_k,
                         input logic [2:0] a_pre, input logic [2:0] a_post,
                         input logic [2:0] b_pre, input logic [2:0] b_post);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clk);
            check({tag, ":ena_a"}, 32'(ena_a), 32'((k < rise_k) ? a_pre : a_post));
            check({tag, ":ena_b"}, 32'(ena_b), 32'((k < rise_k) ? b_pre : b_post));
            check({tag, ":done"},  32'(done),  32'(k == done_k));
            check({tag, ":busy"},  32'(busy),  32'(k < done_k));
            check({tag, ":ready"}, 32'(req_ready), 32'(k >= done_k));
            check({tag, ":err"},   32'(err),   32'(0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_chan  = 2'd0;
        req_bus   = 1'b0;
        req_conn  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst:ena_a", 32'(ena_a), 32'(0));
        check("rst:ena_b", 32'(ena_b), 32'(0));
        check("rst:ready", 32'(req_ready), 32'(1));
        check("rst:busy",  32'(busy), 32'(0));
        check("rst:done",  32'(done), 32'(0));
        check("rst:err",   32'(err), 32'(0));

        send(2'd2, 1'b0, 1'b1);
        track("c2a", 13, 4, 12, 3'b000, 3'b100, 3'b000, 3'b000);

        send(2'd1, 1'b0, 1'b1);
        track("c1a", 13, 4, 12, 3'b000, 3'b010, 3'b000, 3'b000);

        send(2'd1, 1'b1, 1'b1);
        track("c1b", 13, 4, 12, 3'b000, 3'b000, 3'b000, 3'b010);

        send(2'd1, 1'b1, 1'b1);
        track("noop_c1b", 1, 0, 0, 3'b000, 3'b000, 3'b010, 3'b010);

        send(2'd1, 1'b1, 1'b0);
        track("d1b", 5, 0, 4, 3'b000, 3'b000, 3'b000, 3'b000);

        send(2'd0, 1'b0, 1'b0);
        track("noop_d0a", 1, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);

        send(2'd3, 1'b0, 1'b1);
        check("bad:err",   32'(err), 32'(1));
        check("bad:done",  32'(done), 32'(0));
        check("bad:ready", 32'(req_ready), 32'(1));
        check("bad:busy",  32'(busy), 32'(0));
        check("bad:ena_a", 32'(ena_a), 32'(0));
        @(negedge clk);
        check("bad:err_clr", 32'(err), 32'(0));
        check("bad:done2",   32'(done), 32'(0));

        send(2'd0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("mid:ena_a_up", 32'(ena_a), 32'(3'b001));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid:ena_a", 32'(ena_a), 32'(0));
        check("mid:ena_b", 32'(ena_b), 32'(0));
        check("mid:ready", 32'(req_ready), 32'(1));
        check("mid:busy",  32'(busy), 32'(0));
        done_seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("mid:no_done", 32'(done_seen), 32'(0));

        reset     = 1'b1;
        req_valid = 1'b1;
        req_chan  = 2'd2;
        req_bus   = 1'b0;
        req_conn  = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        check("rstreq:busy",  32'(busy), 32'(0));
        check("rstreq:ready", 32'(req_ready), 32'(1));
        repeat (6) @(negedge clk);
        check("rstreq:ena_a", 32'(ena_a), 32'(0));
        check("rstreq:busy2", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
